// File: rtl/line_fetch.sv
// line_fetch: fetches one image line of 32-bit RGBX pixels from frame memory
// into an on-chip line buffer, hands it to the per-line filter word by word
// (first-word-fall-through), and waits for the filter's write-back before
// fetching the next line. One FRAME_START walks a whole frame.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   frame_start       one-cycle pulse; starts a frame when idle
//   frame_base        byte address of line 0, sampled with an accepted frame_start
//   rd_req/rd_ack     memory read request (held until ack) and its acceptance
//   rd_addr, rd_len   line start byte address and word count of the request
//   rd_valid/rd_data  returning read beats
//   read_line_done    one-cycle pulse when the line buffer is full
//   read_posy         line index of the buffered line (held after the pulse)
//   in_de/in_data     filter pull strobe and current FWFT word
//   write_line_done   downstream finished writing the line
//   busy              high whenever a frame is in progress
//   frame_done        one-cycle pulse after the last line's write-back
//   err_underflow     sticky; pull with no word available
//   err_overflow      sticky; read beat beyond the line length
module line_fetch #(
  parameter  int unsigned WIDTH  = 1600,
  parameter  int unsigned HEIGHT = 1200,
  parameter  int unsigned STRIDE = 6400,
  parameter  int unsigned ADDR_W = 32,
  localparam int unsigned CNT_W  = 12,
  localparam int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_len,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              read_line_done,
  output logic [CNT_W-1:0]  read_posy,
  input  logic              in_de,
  output logic [DATA_W-1:0] in_data,
  input  logic              write_line_done,
  output logic              busy,
  output logic              frame_done,
  output logic              err_underflow,
  output logic              err_overflow
);

  localparam int unsigned      BUF_AW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LINE_LEN = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    FILL   = 3'd2,
    DONE   = 3'd3,
    DRAIN  = 3'd4,
    WAITWB = 3'd5
  } state_t;

  state_t state;
  state_t state_d;

  logic [CNT_W-1:0]  posy;
  logic [CNT_W-1:0]  wcnt;
  logic [CNT_W-1:0]  rcnt;
  logic [CNT_W-1:0]  rcnt_d;
  logic [ADDR_W-1:0] line_addr;
  logic              wb_seen;

  logic              frame_go;
  logic              buf_we;
  logic              pull_ok;
  logic              line_adv;
  logic              frame_end;
  logic              beat_extra;

  logic [DATA_W-1:0] line_buf [WIDTH];

  // Next-state and per-cycle strobes
  always_comb begin
    state_d   = state;
    rcnt_d    = rcnt;
    frame_go  = 1'b0;
    buf_we    = 1'b0;
    pull_ok   = 1'b0;
    line_adv  = 1'b0;
    frame_end = 1'b0;

    unique case (state)
      IDLE: begin
        if (frame_start) begin
          frame_go = 1'b1;
          state_d  = REQ;
        end
      end

      REQ: begin
        if (rd_ack) begin
          state_d = FILL;
        end
      end

      FILL: begin
        if (rd_valid) begin
          buf_we = 1'b1;
          if (wcnt == LAST_COL) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        rcnt_d  = '0;
        state_d = DRAIN;
      end

      DRAIN: begin
        if (in_de && (rcnt < LINE_LEN)) begin
          pull_ok = 1'b1;
          rcnt_d  = rcnt + CNT_W'(1);
          if (rcnt == LAST_COL) begin
            state_d = WAITWB;
          end
        end
      end

      WAITWB: begin
        if (wb_seen) begin
          if (posy == LAST_ROW) begin
            frame_end = 1'b1;
            state_d   = IDLE;
          end else begin
            line_adv = 1'b1;
            state_d  = REQ;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Beats arriving once the line is complete; stray beats in IDLE are dropped silently
  assign beat_extra = rd_valid && ((state == DONE) || (state == DRAIN) || (state == WAITWB));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Datapath, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      posy           <= '0;
      wcnt           <= '0;
      rcnt           <= '0;
      line_addr      <= '0;
      wb_seen        <= 1'b0;
      rd_req         <= 1'b0;
      rd_len         <= '0;
      read_line_done <= 1'b0;
      read_posy      <= '0;
      in_data        <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      err_underflow  <= 1'b0;
      err_overflow   <= 1'b0;
    end else begin
      // Line address advances incrementally, so it wraps modulo 2^ADDR_W
      if (frame_go) begin
        line_addr <= frame_base;
        posy      <= '0;
      end else if (line_adv) begin
        line_addr <= line_addr + ADDR_W'(STRIDE);
        posy      <= posy + CNT_W'(1);
      end

      if ((state == REQ) && rd_ack) begin
        wcnt <= '0;
      end else if (buf_we) begin
        wcnt <= wcnt + CNT_W'(1);
      end

      rcnt <= rcnt_d;

      // Write-back may arrive while still draining; remember it once per line
      if (line_adv || frame_end || (state == IDLE)) begin
        wb_seen <= 1'b0;
      end else if (write_line_done && ((state == DRAIN) || (state == WAITWB))) begin
        wb_seen <= 1'b1;
      end

      rd_req         <= (state_d == REQ);
      rd_len         <= (state_d == REQ) ? LINE_LEN : '0;
      read_line_done <= (state_d == DONE);
      if (state_d == DONE) begin
        read_posy <= posy;
      end

      // Registered read of the next word: ready one cycle after DONE, and one
      // cycle after each pull, so back-to-back pulls are sustained
      if (state_d == DRAIN) begin
        in_data <= line_buf[rcnt_d[BUF_AW-1:0]];
      end

      busy       <= (state_d != IDLE);
      frame_done <= frame_end;

      if (in_de && !pull_ok) begin
        err_underflow <= 1'b1;
      end
      if (beat_extra) begin
        err_overflow <= 1'b1;
      end
    end
  end

  assign rd_addr = line_addr;

  // Line buffer write port (no reset so it can map to block RAM)
  always_ff @(posedge clk) begin
    if (buf_we) begin
      line_buf[wcnt[BUF_AW-1:0]] <= rd_data;
    end
  end

endmodule

// File: tb/tb_line_fetch.sv
// tb_line_fetch: directed-sequence bench for line_fetch with random pixel data,
// random request/return gaps and a random frame base; expectations come from
// a line-level model (base + y*STRIDE addresses, per-line word arrays).
module tb_line_fetch;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned HEIGHT = 2;
  localparam int unsigned STRIDE = 32;
  localparam int unsigned ADDR_W = 32;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic [31:0] frame_base;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [11:0] rd_len;
  logic        rd_ack;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        read_line_done;
  logic [11:0] read_posy;
  logic        in_de;
  logic [31:0] in_data;
  logic        write_line_done;
  logic        busy;
  logic        frame_done;
  logic        err_underflow;
  logic        err_overflow;

  int checks;
  int failures;

  logic [31:0] model_base;
  logic        unf_exp;
  logic        ovf_exp;

  line_fetch #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .STRIDE(STRIDE),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_start    (frame_start),
    .frame_base     (frame_base),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_len         (rd_len),
    .rd_ack         (rd_ack),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .read_line_done (read_line_done),
    .read_posy      (read_posy),
    .in_de          (in_de),
    .in_data        (in_data),
    .write_line_done(write_line_done),
    .busy           (busy),
    .frame_done     (frame_done),
    .err_underflow  (err_underflow),
    .err_overflow   (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk1 ({tag, "_rd_req"},     rd_req,         1'b0);
    chk32({tag, "_rd_addr"},    rd_addr,        32'h0);
    chk12({tag, "_rd_len"},     rd_len,         12'h0);
    chk1 ({tag, "_line_done"},  read_line_done, 1'b0);
    chk12({tag, "_posy"},       read_posy,      12'h0);
    chk32({tag, "_in_data"},    in_data,        32'h0);
    chk1 ({tag, "_busy"},       busy,           1'b0);
    chk1 ({tag, "_frame_done"}, frame_done,     1'b0);
    chk1 ({tag, "_underflow"},  err_underflow,  1'b0);
    chk1 ({tag, "_overflow"},   err_overflow,   1'b0);
  endtask

  task automatic start_frame(input logic [31:0] base);
    frame_base  = base;
    frame_start = 1'b1;
    model_base  = base;
    @(negedge clk);
    frame_start = 1'b0;
    chk1("busy_after_start", busy, 1'b1);
  endtask

  // One line: request handshake, fill, drain, write-back.
  // wld_at >= 0 pulses write_line_done together with that pull; -1 holds it
  // for three cycles after the drain.
  task automatic run_line(input int y, input int ack_dly, input int extra,
                          input bit b2b, input int wld_at, input bit poke,
                          input bit last_line);
    logic [31:0] words [WIDTH];
    logic [31:0] exp_addr;
    int n;
    exp_addr = model_base + 32'(y) * 32'(STRIDE);

    n = 0;
    while ((rd_req !== 1'b1) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    chk1("req_seen", rd_req, 1'b1);
    for (int i = 0; i < ack_dly; i++) begin
      chk1 ("req_hold", rd_req, 1'b1);
      chk32("req_addr_hold", rd_addr, exp_addr);
      chk12("req_len", rd_len, 12'(WIDTH));
      @(negedge clk);
    end
    chk32("req_addr", rd_addr, exp_addr);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    chk1("req_drop", rd_req, 1'b0);

    for (int k = 0; k < int'(WIDTH); k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      words[k] = $urandom;
      rd_valid = 1'b1;
      rd_data  = words[k];
      @(negedge clk);
      rd_valid = 1'b0;
    end
    chk1 ("line_done_pulse", read_line_done, 1'b1);
    chk12("line_done_posy", read_posy, 12'(y));

    rd_valid = (extra > 0);
    rd_data  = $urandom;
    @(negedge clk);
    chk1 ("line_done_one_cycle", read_line_done, 1'b0);
    chk12("posy_held", read_posy, 12'(y));
    rd_valid = (extra > 1);
    rd_data  = $urandom;
    @(negedge clk);
    rd_valid = 1'b0;
    if (extra > 0) ovf_exp = 1'b1;
    chk1("overflow_flag", err_overflow, ovf_exp);

    for (int k = 0; k < int'(WIDTH); k++) begin
      if (!b2b) begin
        repeat ($urandom_range(0, 2)) begin
          chk32("in_data_stable", in_data, words[k]);
          @(negedge clk);
        end
      end
      chk32("in_data", in_data, words[k]);
      in_de           = 1'b1;
      write_line_done = (k == wld_at);
      @(negedge clk);
      in_de           = 1'b0;
      write_line_done = 1'b0;
    end
    chk1("underflow_after_drain", err_underflow, unf_exp);

    if (wld_at >= 0) begin
      if (last_line) begin
        chk1("frame_done_early", frame_done, 1'b0);
        @(negedge clk);
        chk1("frame_done_after_drain", frame_done, 1'b1);
        chk1("idle_after_frame", busy, 1'b0);
        @(negedge clk);
        chk1("frame_done_one_cycle", frame_done, 1'b0);
      end else begin
        chk1("req_early", rd_req, 1'b0);
        @(negedge clk);
        chk1("req_after_drain", rd_req, 1'b1);
      end
    end else begin
      if (poke) begin
        in_de = 1'b1;
        @(negedge clk);
        in_de   = 1'b0;
        unf_exp = 1'b1;
        chk1("underflow_set", err_underflow, 1'b1);
      end
      repeat ($urandom_range(1, 3)) begin
        chk1("wait_no_req", rd_req, 1'b0);
        chk1("wait_no_frame_done", frame_done, 1'b0);
        chk1("wait_busy", busy, 1'b1);
        @(negedge clk);
      end
      write_line_done = 1'b1;
      for (int i = 1; i <= 3; i++) begin
        @(negedge clk);
        if (i == 3) write_line_done = 1'b0;
        if (last_line) chk1("frame_done_wld", frame_done, i == 2);
        else           chk1("req_after_wld", rd_req, i >= 2);
      end
      if (last_line) chk1("idle_after_frame", busy, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] base2;
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    frame_start     = 1'b0;
    frame_base      = 32'h0;
    rd_ack          = 1'b0;
    rd_valid        = 1'b0;
    rd_data         = 32'h0;
    in_de           = 1'b0;
    write_line_done = 1'b0;
    model_base      = 32'h0;
    unf_exp         = 1'b0;
    ovf_exp         = 1'b0;

    repeat (2) @(negedge clk);
    chk_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("post_reset");

    // Frame 1: base 0x1000, slow ack + overflow + back-to-back drain + underflow on line 0,
    // write-back during drain on line 1
    start_frame(32'h0000_1000);
    run_line(0, 5, 2, 1'b1, -1, 1'b1, 1'b0);
    run_line(1, 0, 0, 1'b0,  4, 1'b0, 1'b1);
    chk1("overflow_sticky", err_overflow, 1'b1);
    chk1("underflow_sticky", err_underflow, 1'b1);

    // Reset in the middle of a fill, with stray beats afterwards
    start_frame(32'h0000_2000);
    while (rd_req !== 1'b1) @(negedge clk);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    repeat (3) begin
      rd_valid = 1'b1;
      rd_data  = $urandom;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk_quiet("async_reset");
    @(negedge clk);
    rst_n   = 1'b1;
    unf_exp = 1'b0;
    ovf_exp = 1'b0;
    repeat (3) begin
      rd_data = $urandom;
      @(negedge clk);
    end
    rd_valid = 1'b0;
    chk_quiet("stray_beats");

    // Frame 2: random base near the top of memory so line 1 wraps; ignored frame_start mid-frame
    base2 = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    start_frame(base2);
    run_line(0, $urandom_range(0, 3), 0, 1'b0, 5, 1'b0, 1'b0);
    frame_base  = ~base2;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    run_line(1, 2, 0, 1'b0, -1, 1'b1, 1'b1);
    chk1("overflow_clear_frame2", err_overflow, 1'b0);
    chk1("underflow_frame2", err_underflow, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
